// File: rtl/task_dispatch_ctrl_if.sv
// Bus bundle for task_dispatch_ctrl: UART RX bytes in, task payload out,
// task results in, TX bytes out, plus status. The slave modport is the controller side.
interface task_dispatch_ctrl_if #(
   parameter int NUM_TASKS = 8
);
   localparam int SEL_W = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;

   logic             i_rx_valid;
   logic [7:0]       i_rx_data;
   logic [SEL_W-1:0] o_task_sel;
   logic             o_task_valid;
   logic             o_task_first;
   logic             o_task_last;
   logic [7:0]       o_task_data;
   logic             i_task_valid;
   logic             i_task_last;
   logic [15:0]      i_task_data;
   logic             o_tx_valid;
   logic [7:0]       o_tx_data;
   logic             i_tx_ready;
   logic             o_busy;
   logic             o_err;
   logic [1:0]       o_err_code;

   modport slave (
      input  i_rx_valid, i_rx_data, i_task_valid, i_task_last, i_task_data, i_tx_ready,
      output o_task_sel, o_task_valid, o_task_first, o_task_last, o_task_data,
      output o_tx_valid, o_tx_data, o_busy, o_err, o_err_code
   );

   modport master (
      output i_rx_valid, i_rx_data, i_task_valid, i_task_last, i_task_data, i_tx_ready,
      input  o_task_sel, o_task_valid, o_task_first, o_task_last, o_task_data,
      input  o_tx_valid, o_tx_data, o_busy, o_err, o_err_code
   );
endinterface

// File: rtl/task_dispatch_ctrl.sv
// UART-framed task dispatcher: decodes id/length/payload frames, streams the payload
// to the selected task, buffers its 16-bit results and sends them back MSB byte first.
module task_dispatch_ctrl #(
   parameter int NUM_TASKS  = 8,
   parameter int TIMEOUT    = 1024,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   task_dispatch_ctrl_if.slave bus
);
   localparam int SW = (NUM_TASKS > 1) ? $clog2(NUM_TASKS) : 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [8:0]    NT_W     = 9'(NUM_TASKS);
   localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ONE  = TW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_RESULT  = 3'd3,
      S_DRAIN   = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic [SW-1:0] sel_q, sel_d;
   logic [7:0]    len_cnt_q, len_cnt_d;
   logic          first_pend_q, first_pend_d;
   logic          task_valid_q, task_valid_d;
   logic          task_first_q, task_first_d;
   logic          task_last_q, task_last_d;
   logic [7:0]    task_data_q, task_data_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [15:0]   mem_q [FIFO_DEPTH];
   logic [15:0]   mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          tx_valid_q, tx_valid_d;
   logic [7:0]    tx_data_q, tx_data_d;
   logic          tx_lsb_q, tx_lsb_d;
   logic          busy_q, busy_d;
   logic          err_q, err_d;
   logic [1:0]    err_code_q, err_code_d;

   logic rx_idle_s, id_ok_s, bad_id_s, rx_len_s, zero_len_s, rx_pay_s, last_byte_s;
   logic in_res_s, push_s, pop_s, full_s, push_ok_s, ovf_s, timeout_s;

   assign rx_idle_s   = (state_q == S_IDLE) && bus.i_rx_valid;
   assign id_ok_s     = ({1'b0, bus.i_rx_data} < NT_W);
   assign bad_id_s    = rx_idle_s && !id_ok_s;
   assign rx_len_s    = (state_q == S_LEN) && bus.i_rx_valid;
   assign zero_len_s  = rx_len_s && (bus.i_rx_data == 8'd0);
   assign rx_pay_s    = (state_q == S_PAYLOAD) && bus.i_rx_valid;
   assign last_byte_s = rx_pay_s && (len_cnt_q == 8'd1);
   assign in_res_s    = (state_q == S_RESULT);
   assign push_s      = in_res_s && bus.i_task_valid;
   // A word leaves the FIFO only once its LSB byte is accepted.
   assign pop_s       = tx_valid_q && bus.i_tx_ready && tx_lsb_q;
   assign full_s      = (count_q == CNT_FULL);
   assign push_ok_s   = push_s && (!full_s || pop_s);
   assign ovf_s       = push_s && !push_ok_s;
   assign timeout_s   = in_res_s && !bus.i_task_valid && (tmo_cnt_q == TMO_LAST);

   // FSM state register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (rx_idle_s && id_ok_s) state_d = S_LEN; else state_d = S_IDLE;
         S_LEN:     if (zero_len_s) state_d = S_IDLE;
                    else if (rx_len_s) state_d = S_PAYLOAD;
                    else state_d = S_LEN;
         S_PAYLOAD: if (last_byte_s) state_d = S_RESULT; else state_d = S_PAYLOAD;
         S_RESULT:  if (timeout_s) state_d = S_IDLE;
                    else if (push_s && bus.i_task_last) state_d = S_DRAIN;
                    else state_d = S_RESULT;
         S_DRAIN:   if ((count_q == {CW{1'b0}}) && !tx_valid_q) state_d = S_IDLE;
                    else state_d = S_DRAIN;
         default:   state_d = S_IDLE;
      endcase
   end

   // Output, FIFO, serializer and error decode
   always_comb begin
      sel_d        = sel_q;
      task_valid_d = 1'b0;
      task_first_d = 1'b0;
      task_last_d  = 1'b0;
      task_data_d  = task_data_q;
      busy_d       = (state_d != S_IDLE);
      if (rx_idle_s && id_ok_s) sel_d = bus.i_rx_data[SW-1:0]; else sel_d = sel_q;

      if (rx_len_s && !zero_len_s) begin
         len_cnt_d    = bus.i_rx_data;
         first_pend_d = 1'b1;
      end else if (rx_pay_s) begin
         task_valid_d = 1'b1;
         task_first_d = first_pend_q;
         task_last_d  = (len_cnt_q == 8'd1);
         task_data_d  = bus.i_rx_data;
         len_cnt_d    = len_cnt_q - 8'd1;
         first_pend_d = 1'b0;
      end else begin
         len_cnt_d    = len_cnt_q;
         first_pend_d = first_pend_q;
      end

      if (in_res_s && !bus.i_task_valid && !timeout_s) tmo_cnt_d = tmo_cnt_q + TMO_ONE;
      else tmo_cnt_d = {TW{1'b0}};

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = bus.i_task_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) rd_ptr_d = rd_ptr_q + PTR_ONE; else rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, pop_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      tx_lsb_d   = tx_lsb_q;
      if (timeout_s) begin
         wr_ptr_d   = {PW{1'b0}};
         rd_ptr_d   = {PW{1'b0}};
         count_d    = {CW{1'b0}};
         tx_valid_d = 1'b0;
         tx_lsb_d   = 1'b0;
      end else if (tx_valid_q && bus.i_tx_ready) begin
         if (!tx_lsb_q) begin
            tx_data_d = mem_q[rd_ptr_q][7:0];
            tx_lsb_d  = 1'b1;
         end else begin
            tx_valid_d = 1'b0;
            tx_lsb_d   = 1'b0;
         end
      end else if (!tx_valid_q && (count_q != {CW{1'b0}}) &&
                   ((state_q == S_RESULT) || (state_q == S_DRAIN))) begin
         tx_valid_d = 1'b1;
         tx_data_d  = mem_q[rd_ptr_q][15:8];
         tx_lsb_d   = 1'b0;
      end else begin
         tx_valid_d = tx_valid_q;
      end

      err_d      = 1'b0;
      err_code_d = err_code_q;
      if (ovf_s || timeout_s) begin
         err_d      = 1'b1;
         err_code_d = 2'd3;
      end else if (zero_len_s) begin
         err_d      = 1'b1;
         err_code_d = 2'd2;
      end else if (bad_id_s) begin
         err_d      = 1'b1;
         err_code_d = 2'd1;
      end else begin
         err_d = 1'b0;
      end
   end

   // Datapath and output registers
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sel_q        <= {SW{1'b0}};
         len_cnt_q    <= 8'd0;
         first_pend_q <= 1'b0;
         task_valid_q <= 1'b0;
         task_first_q <= 1'b0;
         task_last_q  <= 1'b0;
         task_data_q  <= 8'd0;
         tmo_cnt_q    <= {TW{1'b0}};
         mem_q        <= '{default: 16'h0000};
         wr_ptr_q     <= {PW{1'b0}};
         rd_ptr_q     <= {PW{1'b0}};
         count_q      <= {CW{1'b0}};
         tx_valid_q   <= 1'b0;
         tx_data_q    <= 8'd0;
         tx_lsb_q     <= 1'b0;
         busy_q       <= 1'b0;
         err_q        <= 1'b0;
         err_code_q   <= 2'd0;
      end else begin
         sel_q        <= sel_d;
         len_cnt_q    <= len_cnt_d;
         first_pend_q <= first_pend_d;
         task_valid_q <= task_valid_d;
         task_first_q <= task_first_d;
         task_last_q  <= task_last_d;
         task_data_q  <= task_data_d;
         tmo_cnt_q    <= tmo_cnt_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         tx_valid_q   <= tx_valid_d;
         tx_data_q    <= tx_data_d;
         tx_lsb_q     <= tx_lsb_d;
         busy_q       <= busy_d;
         err_q        <= err_d;
         err_code_q   <= err_code_d;
      end
   end

   assign bus.o_task_sel   = sel_q;
   assign bus.o_task_valid = task_valid_q;
   assign bus.o_task_first = task_first_q;
   assign bus.o_task_last  = task_last_q;
   assign bus.o_task_data  = task_data_q;
   assign bus.o_tx_valid   = tx_valid_q;
   assign bus.o_tx_data    = tx_data_q;
   assign bus.o_busy       = busy_q;
   assign bus.o_err        = err_q;
   assign bus.o_err_code   = err_code_q;
endmodule

// File: tb/tb_task_dispatch_ctrl.sv
// Directed bench for task_dispatch_ctrl: frames, result serialization, errors,
// overflow, timeout and mid-frame reset, with hand-computed expectations.
module tb_task_dispatch_ctrl;
   logic       clk;
   logic       rst_n;
   int         total;
   int         bad;
   logic [7:0] tx_bytes [$];
   logic [7:0] exp_ovf [8];

   task_dispatch_ctrl_if #(.NUM_TASKS(8)) bus ();

   task_dispatch_ctrl #(
      .NUM_TASKS(8),
      .TIMEOUT(1024),
      .FIFO_DEPTH(4)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Strobe one RX byte; returns at the negedge where its registered effects are visible.
   task automatic rx_byte(input logic [7:0] b);
      @(negedge clk);
      check_val("task_valid_before_strobe", 32'(bus.o_task_valid), 32'd0);
      bus.i_rx_valid = 1'b1;
      bus.i_rx_data  = b;
      @(negedge clk);
      bus.i_rx_valid = 1'b0;
   endtask

   task automatic check_task(input string tag, input logic [7:0] d, input logic f, input logic l);
      check_val({tag, "_valid"}, 32'(bus.o_task_valid), 32'd1);
      check_val({tag, "_data"},  32'(bus.o_task_data),  32'(d));
      check_val({tag, "_first"}, 32'(bus.o_task_first), 32'(f));
      check_val({tag, "_last"},  32'(bus.o_task_last),  32'(l));
   endtask

   // Collect accepted TX bytes at negedges, bounded by a cycle budget.
   task automatic collect_tx(input int n);
      int guard;
      tx_bytes.delete();
      guard = 0;
      while (tx_bytes.size() < n && guard < 100) begin
         if (bus.o_tx_valid && bus.i_tx_ready) tx_bytes.push_back(bus.o_tx_data);
         @(negedge clk);
         guard++;
      end
      check_val("tx_byte_count", 32'(tx_bytes.size()), 32'(n));
   endtask

   task automatic check_tx(input int idx, input logic [7:0] exp);
      logic [31:0] got;
      got = (idx < tx_bytes.size()) ? 32'(tx_bytes[idx]) : 32'hFFFF_FFFF;
      check_val($sformatf("tx_byte%0d", idx), got, 32'(exp));
   endtask

   task automatic send_word(input logic [15:0] d, input logic l);
      @(negedge clk);
      bus.i_task_valid = 1'b1;
      bus.i_task_data  = d;
      bus.i_task_last  = l;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.i_rx_valid   = 1'b0;
      bus.i_rx_data    = 8'h00;
      bus.i_task_valid = 1'b0;
      bus.i_task_last  = 1'b0;
      bus.i_task_data  = 16'h0000;
      bus.i_tx_ready   = 1'b0;
      exp_ovf = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};

      repeat (2) @(negedge clk);
      check_val("rst_task_valid", 32'(bus.o_task_valid), 32'd0);
      check_val("rst_task_sel",   32'(bus.o_task_sel),   32'd0);
      check_val("rst_tx_valid",   32'(bus.o_tx_valid),   32'd0);
      check_val("rst_busy",       32'(bus.o_busy),       32'd0);
      check_val("rst_err",        32'(bus.o_err),        32'd0);
      check_val("rst_err_code",   32'(bus.o_err_code),   32'd0);
      rst_n = 1'b1;
      bus.i_tx_ready = 1'b1;
      @(negedge clk);
      check_val("idle_busy", 32'(bus.o_busy), 32'd0);

      // Three-byte frame to task 2, one result word
      rx_byte(8'h02);
      check_val("f1_busy", 32'(bus.o_busy), 32'd1);
      check_val("f1_sel",  32'(bus.o_task_sel), 32'd2);
      rx_byte(8'h03);
      check_val("f1_len_no_strobe", 32'(bus.o_task_valid), 32'd0);
      rx_byte(8'hA1);
      check_task("f1_b1", 8'hA1, 1'b1, 1'b0);
      rx_byte(8'hB2);
      check_task("f1_b2", 8'hB2, 1'b0, 1'b0);
      rx_byte(8'hC3);
      check_task("f1_b3", 8'hC3, 1'b0, 1'b1);
      @(negedge clk);
      check_val("f1_strobe_pulse", 32'(bus.o_task_valid), 32'd0);
      check_val("f1_busy_result",  32'(bus.o_busy), 32'd1);
      send_word(16'h1234, 1'b1);
      @(negedge clk);
      bus.i_task_valid = 1'b0;
      collect_tx(2);
      check_tx(0, 8'h12);
      check_tx(1, 8'h34);
      check_val("f1_busy_drain", 32'(bus.o_busy), 32'd1);
      @(negedge clk);
      check_val("f1_busy_fall", 32'(bus.o_busy), 32'd0);

      // Bad task id, then a one-byte frame
      rx_byte(8'h09);
      check_val("badid_err",  32'(bus.o_err), 32'd1);
      check_val("badid_code", 32'(bus.o_err_code), 32'd1);
      check_val("badid_busy", 32'(bus.o_busy), 32'd0);
      @(negedge clk);
      check_val("badid_pulse", 32'(bus.o_err), 32'd0);
      rx_byte(8'h01);
      check_val("f2_sel", 32'(bus.o_task_sel), 32'd1);
      rx_byte(8'h01);
      rx_byte(8'h55);
      check_task("f2_b1", 8'h55, 1'b1, 1'b1);
      send_word(16'hABCD, 1'b1);
      @(negedge clk);
      bus.i_task_valid = 1'b0;
      collect_tx(2);
      check_tx(0, 8'hAB);
      check_tx(1, 8'hCD);
      @(negedge clk);
      check_val("f2_busy_fall", 32'(bus.o_busy), 32'd0);

      // Zero length
      rx_byte(8'h00);
      rx_byte(8'h00);
      check_val("zlen_err",  32'(bus.o_err), 32'd1);
      check_val("zlen_code", 32'(bus.o_err_code), 32'd2);
      check_val("zlen_busy", 32'(bus.o_busy), 32'd0);

      // FIFO overflow with TX stalled
      rx_byte(8'h03);
      rx_byte(8'h01);
      rx_byte(8'h77);
      bus.i_tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_word({2{8'(8'h11 * (i + 1))}}, (i == 4));
      end
      @(negedge clk);
      bus.i_task_valid = 1'b0;
      bus.i_task_last  = 1'b0;
      check_val("ovf_err",  32'(bus.o_err), 32'd1);
      check_val("ovf_code", 32'(bus.o_err_code), 32'd3);
      check_val("ovf_busy", 32'(bus.o_busy), 32'd1);
      bus.i_tx_ready = 1'b1;
      collect_tx(8);
      for (int i = 0; i < 8; i++) check_tx(i, exp_ovf[i]);
      @(negedge clk);
      check_val("ovf_busy_fall", 32'(bus.o_busy), 32'd0);

      // Timeout with a stalled TX byte in flight
      rx_byte(8'h04);
      rx_byte(8'h01);
      rx_byte(8'h99);
      bus.i_tx_ready   = 1'b0;
      bus.i_task_valid = 1'b1;
      bus.i_task_last  = 1'b0;
      bus.i_task_data  = 16'hBEEF;
      @(negedge clk);
      bus.i_task_valid = 1'b0;
      repeat (1023) @(negedge clk);
      check_val("tmo_early_err",  32'(bus.o_err), 32'd0);
      check_val("tmo_early_busy", 32'(bus.o_busy), 32'd1);
      check_val("tmo_tx_hold",    32'(bus.o_tx_data), 32'hBE);
      check_val("tmo_tx_valid",   32'(bus.o_tx_valid), 32'd1);
      @(negedge clk);
      check_val("tmo_err",      32'(bus.o_err), 32'd1);
      check_val("tmo_code",     32'(bus.o_err_code), 32'd3);
      check_val("tmo_busy",     32'(bus.o_busy), 32'd0);
      check_val("tmo_tx_abort", 32'(bus.o_tx_valid), 32'd0);
      bus.i_tx_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_val("tmo_flushed", 32'(bus.o_tx_valid), 32'd0);

      // Reset mid-payload
      rx_byte(8'h05);
      rx_byte(8'h03);
      rx_byte(8'h11);
      check_task("rst_pre", 8'h11, 1'b1, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("arst_task_valid", 32'(bus.o_task_valid), 32'd0);
      check_val("arst_task_data",  32'(bus.o_task_data),  32'd0);
      check_val("arst_task_sel",   32'(bus.o_task_sel),   32'd0);
      check_val("arst_busy",       32'(bus.o_busy),       32'd0);
      check_val("arst_err_code",   32'(bus.o_err_code),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      rx_byte(8'h06);
      check_val("post_rst_sel",  32'(bus.o_task_sel), 32'd6);
      check_val("post_rst_busy", 32'(bus.o_busy), 32'd1);
      check_val("post_rst_err",  32'(bus.o_err), 32'd0);
      rx_byte(8'h01);
      rx_byte(8'h42);
      check_task("post_rst_b1", 8'h42, 1'b1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
